// File: rtl/fifo2_sync_if.sv
// fifo2_sync_if
// Groups the FIFO control, handshake, data and status signals into one bundle
// so the FIFO and its user connect through a single port.
//   clear        : synchronous flush request (active-high)
//   put / get    : write / read requests
//   data_in      : write data
//   data_out     : read data (registered head word)
//   empty_bar    : low when the FIFO holds no words
//   full_bar     : low when the FIFO holds DEPTH words
//   almost_full  : count >= AF_LEVEL
//   almost_empty : count <= AE_LEVEL
//   count        : number of stored words
//   overflow     : sticky, a put was rejected while full
//   underflow    : sticky, a get was rejected while empty
// master = the FIFO user, slave = the FIFO itself.
interface fifo2_sync_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clear;
  logic             put;
  logic             get;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             empty_bar;
  logic             full_bar;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clear, put, get, data_in,
    input  data_out, empty_bar, full_bar, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clear, put, get, data_in,
    output data_out, empty_bar, full_bar, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo2_sync.sv
// fifo2_sync
// Single-clock FIFO with registered status flags, sticky overflow/underflow
// and a selectable read style (registered read or first-word-fall-through).
//   clk       : single clock, all state changes on the rising edge
//   reset_bar : asynchronous active-low reset
//   fifoBus   : fifo2_sync_if slave port (clear, put, get, data_in, data_out,
//               empty_bar, full_bar, almost_full, almost_empty, count,
//               overflow, underflow)
module fifo2_sync #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic         clk,
  input  logic         reset_bar,
  fifo2_sync_if.slave  fifoBus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_dataOut;

  logic             w_notEmpty;
  logic             w_isFull;
  logic             w_rdEn;
  logic             w_wrEn;
  logic [AW-1:0]    w_rdPtrNext;
  logic [WIDTH-1:0] w_headNext;

  assign w_notEmpty  = (r_count != '0);
  assign w_isFull    = (r_count == CW'(DEPTH));
  // A read frees a slot on the same edge, so a full FIFO still accepts a put
  // when a get is accepted alongside it.
  assign w_rdEn      = fifoBus.get & ~fifoBus.clear & w_notEmpty;
  assign w_wrEn      = fifoBus.put & ~fifoBus.clear & (~w_isFull | w_rdEn);
  assign w_rdPtrNext = r_rdPtr + 1'b1;

  // Next value of the output register. In registered-read mode it loads the
  // head on each accepted read. In fall-through mode it tracks the head word:
  // after a read it becomes the following entry, unless that entry is the one
  // being written this very edge, in which case it comes straight from data_in.
  always_comb begin
    w_headNext = r_dataOut;
    if (FWFT == 0) begin
      if (w_rdEn) w_headNext = r_mem[r_rdPtr];
    end else begin
      if (w_rdEn && (r_count > CW'(1)))
        w_headNext = r_mem[w_rdPtrNext];
      else if (w_wrEn && (!w_notEmpty || w_rdEn))
        w_headNext = fifoBus.data_in;
    end
  end

  // Storage is deliberately not reset; entries are only visible once written.
  always_ff @(posedge clk) begin
    if (w_wrEn) r_mem[r_wrPtr] <= fifoBus.data_in;
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dataOut   <= '0;
    end else if (fifoBus.clear) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_dataOut   <= '0;
    end else begin
      if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_rdEn) r_rdPtr <= w_rdPtrNext;
      case ({w_wrEn, w_rdEn})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (fifoBus.put && !w_wrEn)     r_overflow  <= 1'b1;
      if (fifoBus.get && !w_notEmpty) r_underflow <= 1'b1;
      r_dataOut <= w_headNext;
    end
  end

  // Flags come only from the registered count, never from put/get directly.
  assign fifoBus.count        = r_count;
  assign fifoBus.empty_bar    = w_notEmpty;
  assign fifoBus.full_bar     = ~w_isFull;
  assign fifoBus.almost_full  = (r_count >= CW'(AF_LEVEL));
  assign fifoBus.almost_empty = (r_count <= CW'(AE_LEVEL));
  assign fifoBus.overflow     = r_overflow;
  assign fifoBus.underflow    = r_underflow;
  assign fifoBus.data_out     = r_dataOut;
endmodule

// File: tb/tb_fifo2_sync.sv
// tb_fifo2_sync
// Drives a registered-read instance (dut0) and a fall-through instance (dut1)
// with identical stimulus and compares both against hand-computed values.
module tb_fifo2_sync;
  logic clk = 1'b0;
  logic reset_bar = 1'b0;
  int   numChecks = 0;
  int   numFails  = 0;

  fifo2_sync_if #(.WIDTH(8), .DEPTH(16)) bus0 ();
  fifo2_sync_if #(.WIDTH(8), .DEPTH(16)) bus1 ();

  fifo2_sync #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0))
    dut0 (.clk(clk), .reset_bar(reset_bar), .fifoBus(bus0));
  fifo2_sync #(.DEPTH(16), .WIDTH(8), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1))
    dut1 (.clk(clk), .reset_bar(reset_bar), .fifoBus(bus1));

  always #5 clk = ~clk;

  typedef struct {
    logic       put, get, clear;
    logic [7:0] din;
    logic [4:0] cnt;
    logic       eb, fb, af, ae, ovf, unf;
    logic [7:0] dout0, dout1;
  } vec_t;

  vec_t vecs[34];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive both instances, let one rising edge pass, then sample 1ns later.
  task automatic applyStimulus(input logic p, input logic g, input logic c, input logic [7:0] d);
    bus0.put = p; bus0.get = g; bus0.clear = c; bus0.data_in = d;
    bus1.put = p; bus1.get = g; bus1.clear = c; bus1.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input int cnt, input logic eb, input logic fb,
                            input logic af, input logic ae, input logic ovf, input logic unf);
    checkOutput({tag, " count"},        bus0.count,        cnt);
    checkOutput({tag, " empty_bar"},    bus0.empty_bar,    eb);
    checkOutput({tag, " full_bar"},     bus0.full_bar,     fb);
    checkOutput({tag, " almost_full"},  bus0.almost_full,  af);
    checkOutput({tag, " almost_empty"}, bus0.almost_empty, ae);
    checkOutput({tag, " overflow"},     bus0.overflow,     ovf);
    checkOutput({tag, " underflow"},    bus0.underflow,    unf);
    checkOutput({tag, " count fwft"},   bus1.count,        cnt);
  endtask

  initial begin
    // Fill: 16 puts, one rejected put, 16 gets, one rejected get.
    for (int k = 1; k <= 16; k++)
      vecs[k-1] = '{put:1'b1, get:1'b0, clear:1'b0, din:8'(k), cnt:5'(k), eb:1'b1,
                    fb:(k != 16), af:(k >= 14), ae:(k <= 2), ovf:1'b0, unf:1'b0,
                    dout0:8'h00, dout1:8'h01};
    vecs[16] = '{put:1'b1, get:1'b0, clear:1'b0, din:8'hFF, cnt:5'd16, eb:1'b1, fb:1'b0,
                 af:1'b1, ae:1'b0, ovf:1'b1, unf:1'b0, dout0:8'h00, dout1:8'h01};
    for (int j = 1; j <= 16; j++)
      vecs[16+j] = '{put:1'b0, get:1'b1, clear:1'b0, din:8'h00, cnt:5'(16-j), eb:(j != 16),
                     fb:1'b1, af:((16-j) >= 14), ae:((16-j) <= 2), ovf:1'b1, unf:1'b0,
                     dout0:8'(j), dout1:(j < 16) ? 8'(j+1) : 8'h10};
    vecs[33] = '{put:1'b0, get:1'b1, clear:1'b0, din:8'h00, cnt:5'd0, eb:1'b0, fb:1'b1,
                 af:1'b0, ae:1'b1, ovf:1'b1, unf:1'b1, dout0:8'h10, dout1:8'h10};

    bus0.put = 0; bus0.get = 0; bus0.clear = 0; bus0.data_in = 0;
    bus1.put = 0; bus1.get = 0; bus1.clear = 0; bus1.data_in = 0;

    // Reset state while reset is held across edges.
    repeat (3) @(posedge clk);
    #1;
    checkState("reset", 0, 0, 1, 0, 1, 0, 0);
    checkOutput("reset data_out", bus0.data_out, 8'h00);
    checkOutput("reset data_out fwft", bus1.data_out, 8'h00);
    reset_bar = 1'b1;

    // Table-driven fill / drain sequence.
    for (int i = 0; i < 34; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      applyStimulus(vecs[i].put, vecs[i].get, vecs[i].clear, vecs[i].din);
      checkState(t, vecs[i].cnt, vecs[i].eb, vecs[i].fb, vecs[i].af, vecs[i].ae,
                 vecs[i].ovf, vecs[i].unf);
      checkOutput({t, " data_out"}, bus0.data_out, vecs[i].dout0);
      checkOutput({t, " data_out fwft"}, bus1.data_out, vecs[i].dout1);
    end

    // Clear flushes everything including sticky flags and data_out.
    applyStimulus(0, 0, 1, 8'h00);
    checkState("clear1", 0, 0, 1, 0, 1, 0, 0);
    checkOutput("clear1 data_out", bus0.data_out, 8'h00);
    checkOutput("clear1 data_out fwft", bus1.data_out, 8'h00);

    // Put and get together on empty: put accepted, get rejected.
    applyStimulus(1, 1, 0, 8'h11);
    checkState("emptyPG", 1, 1, 1, 0, 1, 0, 1);
    checkOutput("emptyPG data_out", bus0.data_out, 8'h00);
    checkOutput("emptyPG data_out fwft", bus1.data_out, 8'h11);
    applyStimulus(0, 0, 1, 8'h00);

    // Steady count of 3 with simultaneous put/get across pointer wrap.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 1, 0, 8'(8'h23 + i));
      checkOutput($sformatf("wrap%0d count", i), bus0.count, 3);
      checkOutput($sformatf("wrap%0d data_out", i), bus0.data_out, 8'(8'h20 + i));
      checkOutput($sformatf("wrap%0d data_out fwft", i), bus1.data_out, 8'(8'h21 + i));
    end
    applyStimulus(0, 0, 1, 8'h00);

    // Full FIFO with simultaneous put/get: no overflow, 0xAA read 16th.
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, 0, 8'(8'h30 + i));
    checkOutput("full full_bar", bus0.full_bar, 1'b0);
    applyStimulus(1, 1, 0, 8'hAA);
    checkState("fullPG", 16, 1, 0, 1, 0, 0, 0);
    checkOutput("fullPG data_out", bus0.data_out, 8'h30);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(0, 1, 0, 8'h00);
      checkOutput($sformatf("drain%0d data_out", k), bus0.data_out,
                  (k < 16) ? 8'(8'h30 + k) : 8'hAA);
      checkOutput($sformatf("drain%0d count", k), bus0.count, 16 - k);
    end
    applyStimulus(0, 0, 1, 8'h00);

    // Fall-through: word visible the cycle after its put, no get needed.
    applyStimulus(1, 0, 0, 8'hA5);
    applyStimulus(0, 0, 0, 8'h00);
    checkOutput("fwft empty_bar", bus1.empty_bar, 1'b1);
    checkOutput("fwft data_out", bus1.data_out, 8'hA5);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("fwft get empty_bar", bus1.empty_bar, 1'b0);
    checkOutput("fwft get data_out", bus1.data_out, 8'hA5);

    // Asynchronous reset at count 9, sampled before any further edge.
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 8'(8'h50 + i));
    checkOutput("pre-reset count", bus0.count, 9);
    #2;
    reset_bar = 1'b0;
    #1;
    checkState("asyncReset", 0, 0, 1, 0, 1, 0, 0);
    checkOutput("asyncReset data_out", bus0.data_out, 8'h00);
    checkOutput("asyncReset data_out fwft", bus1.data_out, 8'h00);
    @(negedge clk);
    reset_bar = 1'b1;
    applyStimulus(1, 0, 0, 8'h77);
    checkOutput("postReset count", bus0.count, 1);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("postReset data_out", bus0.data_out, 8'h77);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("postReset underflow", bus0.underflow, 1'b1);

    // Synchronous clear at count 9 overrides a put on the same edge.
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 8'(8'h60 + i));
    checkOutput("pre-clear count", bus0.count, 9);
    applyStimulus(1, 0, 1, 8'hEE);
    checkState("clear2", 0, 0, 1, 0, 1, 0, 0);
    checkOutput("clear2 data_out", bus0.data_out, 8'h00);
    checkOutput("clear2 data_out fwft", bus1.data_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule

// File: doc/fifo2_sync.md
FIFO2_SYNC -- requirements
Module: fifo2_sync

Interface
REQ-001 Parameter DEPTH, default 16, number of entries; SHALL be a power of two, >= 4.
REQ-002 Parameter WIDTH, default 8, data word width in bits.
REQ-003 Parameter AF_LEVEL, default DEPTH-2, almost_full threshold; legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 2, almost_empty threshold; legal range 0..DEPTH-1.
REQ-005 Parameter FWFT, default 0; 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-006 Port clk  input  1  single clock; all state changes on rising edge.
REQ-007 Port reset_bar  input  1  reset; asynchronous, active-low.
REQ-008 Port clear  input  1  synchronous flush, active-high.
REQ-009 Port put  input  1  write request.
REQ-010 Port get  input  1  read request.
REQ-011 Port data_in  input  WIDTH  write data.
REQ-012 Port data_out  output  WIDTH  read data.
REQ-013 Port empty_bar  output  1  low when FIFO is empty.
REQ-014 Port full_bar  output  1  low when FIFO is full.
REQ-015 Port almost_full  output  1  high when count >= AF_LEVEL.
REQ-016 Port almost_empty  output  1  high when count <= AE_LEVEL.
REQ-017 Port count  output  $clog2(DEPTH)+1  current number of stored words.
REQ-018 Port overflow  output  1  sticky; put rejected while full.
REQ-019 Port underflow  output  1  sticky; get rejected while empty.

Function
REQ-020 Write accepted when put=1 and (count<DEPTH or get accepted same edge); word stored at write pointer, pointer advances modulo DEPTH.
REQ-021 Read accepted when get=1 and count>0; read pointer advances modulo DEPTH.
REQ-022 Count: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-023 Full with put=1, get=1: both accepted, count stays DEPTH, oldest word read, new word written in its slot order.
REQ-024 Empty with put=1, get=1: put accepted, get rejected, underflow set, count becomes 1.
REQ-025 Put rejected while full without get: storage and count unchanged, overflow set to 1.
REQ-026 Get rejected while empty: pointers and count unchanged, underflow set to 1, data_out unchanged.
REQ-027 overflow/underflow remain 1 until reset or clear.
REQ-028 empty_bar, full_bar, almost_full, almost_empty derived from registered count only; valid the cycle after the causing edge, no combinational path from put/get.
REQ-029 FWFT=0: data_out is a register loaded with the head word on each accepted read edge (latency 1 cycle); holds value otherwise.
REQ-030 FWFT=1: data_out shows the head word whenever empty_bar=1, with no get needed; first word written to an empty FIFO visible the cycle after its put edge; accepted get presents next word the following cycle; value undefined-but-stable-at-last-head when empty.
REQ-031 clear=1 at an edge: pointers, count, overflow, underflow to 0, data_out to 0; overrides put and get that edge.
REQ-032 Storage array is not reset; contents unreadable until rewritten.

Reset
REQ-033 reset_bar=0 SHALL immediately, without a clock edge, force count=0, pointers=0, data_out=0, overflow=0, underflow=0, empty_bar=0, full_bar=1, almost_empty=1, almost_full=0.
REQ-034 Reset asserted mid-operation discards all stored words; first accepted put after release writes entry 0.
REQ-035 Deassertion of reset_bar takes effect at the next rising clk edge; put/get at that edge is honoured.

Verification (DEPTH=16, WIDTH=8, AF_LEVEL=14, AE_LEVEL=2)
REQ-036 FWFT=0; 16 puts of 0x01..0x10 -> almost_empty drops after 3rd, almost_full rises after 14th, full_bar=0 and count=16 after 16th; 17th put 0xFF -> overflow=1, count=16.
REQ-037 Then 16 gets -> data_out 0x01..0x10 each one cycle after its get edge, empty_bar=0 after last; 17th get -> underflow=1, data_out stays 0x10.
REQ-038 From count=3, put=get=1 for 20 cycles with incrementing data -> count stays 3, output order preserved across pointer wrap.
REQ-039 Full FIFO, put=get=1 with 0xAA -> count=16, overflow stays 0, 0xAA emerges as 16th subsequent read.
REQ-040 FWFT=1; empty FIFO, put 0xA5 -> next cycle empty_bar=1, data_out=0xA5 with get=0; get -> empty_bar=0 next cycle.
REQ-041 Count=9, reset_bar pulsed low between edges -> outputs take REQ-033 values before next edge; repeat with clear=1 -> same values after the edge.
